// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner at the head of the IF stage.
// Issues instruction-memory fetches, arbitrates the next-PC source
// (exception > jump > branch > sequential) and remembers a redirect that
// arrives while a fetch is still outstanding, so the wrong-path response
// can be dropped.
// Build option: define PC_ALIGN_CHECK_EN to turn misaligned branch/jump
// targets into an exception redirect that pulses `misalign`. Without it,
// target bits [1:0] are cleared and `misalign` stays low.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  pc_src,
  output logic        inst_valid,
  output logic        misalign
);

  // Source codes double as redirect priorities: a larger value wins.
  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_EXC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no request outstanding
    ST_FETCH = 2'd1,  // on-path request outstanding
    ST_KILL  = 2'd2   // request outstanding, its response is wrong-path
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] pend_addr_q;
  logic [1:0]  pend_pri_q;
  logic        pend_valid_q;

  logic        redirect_s;
  logic [1:0]  win_pri_s;
  logic [31:0] win_tgt_s;
  logic        mis_s;
  logic        accept_s;

  // Pick the winning redirect source and its (possibly adjusted) target.
  always_comb begin
    redirect_s = exc | jump | branch_taken;
    win_pri_s  = SRC_NONE;
    win_tgt_s  = 32'h0000_0000;
    mis_s      = 1'b0;
    if (exc) begin
      win_pri_s = SRC_EXC;
      win_tgt_s = EXC_VECTOR;
    end else if (jump) begin
      win_pri_s = SRC_JUMP;
      win_tgt_s = jump_target;
    end else if (branch_taken) begin
      win_pri_s = SRC_BRANCH;
      win_tgt_s = branch_target;
    end else begin
      win_pri_s = SRC_NONE;
    end
`ifdef PC_ALIGN_CHECK_EN
    // A misaligned branch/jump target becomes an exception redirect.
    if (((win_pri_s == SRC_JUMP) || (win_pri_s == SRC_BRANCH)) &&
        (win_tgt_s[1:0] != 2'b00)) begin
      win_pri_s = SRC_EXC;
      win_tgt_s = EXC_VECTOR;
      mis_s     = 1'b1;
    end else begin
      mis_s = 1'b0;
    end
`else
    // Without the check, branch/jump targets are silently word-aligned.
    if (win_pri_s != SRC_EXC) begin
      win_tgt_s[1:0] = 2'b00;
    end else begin
      mis_s = 1'b0;
    end
`endif
  end

  // A redirect is accepted unless it loses to an already pending one.
  always_comb begin
    accept_s = redirect_s;
    if ((state_q == ST_KILL) && pend_valid_q && (win_pri_s < pend_pri_q)) begin
      accept_s = 1'b0;
    end else begin
      accept_s = redirect_s;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = req_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign pc_src     = (rst_n && accept_s) ? win_pri_s : SRC_NONE;
  assign misalign   = rst_n & accept_s & mis_s;
  assign inst_valid = imem_ack & (state_q == ST_FETCH) & ~redirect_s;

  // Fetch FSM: owns pc, the request strobe and the pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      pend_addr_q  <= 32'h0000_0000;
      pend_pri_q   <= SRC_NONE;
      pend_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_s) begin
            pc_q <= win_tgt_s;
          end
          if (!stall) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (imem_ack) begin
            // Response consumed; a same-cycle redirect simply overrides pc+4.
            pc_q <= redirect_s ? win_tgt_s : (pc_q + 32'd4);
            if (stall) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              req_q   <= 1'b1;
            end
          end else if (redirect_s) begin
            // Request cannot be withdrawn: park the redirect until the ack.
            pend_addr_q  <= win_tgt_s;
            pend_pri_q   <= win_pri_s;
            pend_valid_q <= 1'b1;
            state_q      <= ST_KILL;
          end
        end

        ST_KILL: begin
          if (imem_ack) begin
            pc_q         <= accept_s ? win_tgt_s : pend_addr_q;
            pend_valid_q <= 1'b0;
            pend_pri_q   <= SRC_NONE;
            if (stall) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              req_q   <= 1'b1;
            end
          end else if (accept_s) begin
            pend_addr_q <= win_tgt_s;
            pend_pri_q  <= win_pri_s;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          req_q        <= 1'b0;
          pend_valid_q <= 1'b0;
          pend_pri_q   <= SRC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ack, branch_taken, jump, exc;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, inst_valid, misalign;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [1:0]  pc_src;

  int total = 0;
  int bad   = 0;

  // Reference model state: outstanding fetch, whether it is wrong-path,
  // and the redirect remembered for when it completes.
  logic [31:0] m_pc, m_pend_tgt;
  int          m_pend_pri;
  bit          m_busy, m_wrong;

  pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc(exc),
    .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src),
    .inst_valid(inst_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic s, input logic a, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic e);
    stall = s; imem_ack = a; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; exc = e;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0);
    #3;
    total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (pc_src !== 2'd0) begin bad++; $display("FAIL reset_pc_src got=%0d exp=0", pc_src); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b exp=0", inst_valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    do_reset();
  endtask

  task automatic test_seq_fetch();
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_bubble got=%b exp=0", imem_req); end
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      total++; if (imem_req !== 1'b1 || inst_valid !== 1'b1) begin bad++; $display("FAIL seq_req_iv%0d got=%b%b exp=11", i, imem_req, inst_valid); end
      step();
    end
  endtask

  task automatic test_ack_wait();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    @(negedge clk);
    total++; if (pc_src !== 2'd2) begin bad++; $display("FAIL wait_jump_src got=%0d exp=2", pc_src); end
    step();
    jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin bad++; $display("FAIL wait_hold%0d got=%h/%b exp=00000010/1", i, imem_addr, imem_req); end
      step();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL wait_iv got=%b exp=1", inst_valid); end
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL wait_next got=%h exp=00000014", imem_addr); end
  endtask

  task automatic test_branch_ack();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL br_ack_iv got=%b exp=0", inst_valid); end
    total++; if (pc_src !== 2'd1) begin bad++; $display("FAIL br_ack_src got=%0d exp=1", pc_src); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin bad++; $display("FAIL br_ack_next got=%h/%b exp=00000200/1", imem_addr, imem_req); end
  endtask

  task automatic test_kill_priority();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    @(negedge clk);
    total++; if (pc_src !== 2'd2) begin bad++; $display("FAIL kill_jump_src got=%0d exp=2", pc_src); end
    step();
    set_in(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (pc_src !== 2'd0) begin bad++; $display("FAIL kill_branch_src got=%0d exp=0", pc_src); end
    total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL kill_hold got=%h/%b exp=00000040/1", imem_addr, imem_req); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    total++; if (pc_src !== 2'd3) begin bad++; $display("FAIL kill_exc_src got=%0d exp=3", pc_src); end
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (inst_valid !== 1'b0 || pc_src !== 2'd0) begin bad++; $display("FAIL kill_ack got=%b/%0d exp=0/0", inst_valid, pc_src); end
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== EXC_VEC) begin bad++; $display("FAIL kill_next got=%h exp=%h", imem_addr, EXC_VEC); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (pc_plus4 !== 32'h0 || inst_valid !== 1'b1) begin bad++; $display("FAIL wrap_plus4 got=%h/%b exp=00000000/1", pc_plus4, inst_valid); end
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_addr;
    logic        exp_mis;
    logic [1:0]  exp_src;
`ifdef PC_ALIGN_CHECK_EN
    exp_addr = EXC_VEC; exp_mis = 1'b1; exp_src = 2'd3;
`else
    exp_addr = 32'h100; exp_mis = 1'b0; exp_src = 2'd2;
`endif
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
    @(negedge clk);
    total++; if (misalign !== exp_mis || pc_src !== exp_src) begin bad++; $display("FAIL mis_pulse got=%b/%0d exp=%b/%0d", misalign, pc_src, exp_mis, exp_src); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total++; if (imem_addr !== exp_addr || misalign !== 1'b0) begin bad++; $display("FAIL mis_next got=%h/%b exp=%h/0", imem_addr, misalign, exp_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_idle%0d got=%b exp=0", i, imem_req); end
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    stall = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stall_keep_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    step();
    imem_ack = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stall_ack_iv got=%b exp=1", inst_valid); end
    step();
    @(negedge clk);
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin bad++; $display("FAIL stall_to_idle got=%b/%h exp=0/00000004", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pc !== RST_PC || imem_req !== 1'b0) begin bad++; $display("FAIL midrst_async got=%h/%b exp=%h/0", pc, imem_req, RST_PC); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_bubble got=%b exp=0", imem_req); end
    step();
    @(negedge clk);
    total++; if (imem_addr !== RST_PC || inst_valid !== 1'b1) begin bad++; $display("FAIL midrst_clean got=%h/%b exp=%h/1", imem_addr, inst_valid, RST_PC); end
  endtask

  task automatic test_random();
    int          pri;
    logic [31:0] tgt;
    bit          mis, accepted, exp_iv;
    do_reset();
    m_pc = RST_PC; m_busy = 1'b0; m_wrong = 1'b0; m_pend_pri = 0; m_pend_tgt = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      imem_ack      = $urandom_range(0, 1) == 1;
      branch_taken  = ($urandom_range(0, 99) < 15);
      jump          = ($urandom_range(0, 99) < 10);
      exc           = ($urandom_range(0, 99) < 5);
      branch_target = $urandom & (($urandom_range(0, 9) < 7) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      jump_target   = $urandom & (($urandom_range(0, 9) < 7) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      @(negedge clk);
      // Who wins this cycle, and where does it go.
      mis = 1'b0;
      if (exc) begin pri = 3; tgt = EXC_VEC; end
      else if (jump) begin pri = 2; tgt = jump_target; end
      else if (branch_taken) begin pri = 1; tgt = branch_target; end
      else begin pri = 0; tgt = 32'h0; end
      if (pri == 1 || pri == 2) begin
`ifdef PC_ALIGN_CHECK_EN
        if (tgt % 4 != 0) begin pri = 3; tgt = EXC_VEC; mis = 1'b1; end
`else
        tgt = tgt - (tgt % 4);
`endif
      end
      accepted = (pri != 0) && (!m_wrong || pri >= m_pend_pri);
      exp_iv   = imem_ack && m_busy && !m_wrong && (pri == 0);
      total++; if (imem_req !== m_busy) begin bad++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, imem_req, m_busy); end
      total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr, m_pc); end
      total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_plus4 n=%0d got=%h exp=%h", n, pc_plus4, m_pc + 32'd4); end
      total++; if (pc_src !== (accepted ? 2'(pri) : 2'd0)) begin bad++; $display("FAIL rnd_src n=%0d got=%0d exp=%0d", n, pc_src, accepted ? pri : 0); end
      total++; if (inst_valid !== exp_iv) begin bad++; $display("FAIL rnd_iv n=%0d got=%b exp=%b", n, inst_valid, exp_iv); end
      total++; if (misalign !== (accepted && mis)) begin bad++; $display("FAIL rnd_mis n=%0d got=%b exp=%b", n, misalign, accepted && mis); end
      // Advance the model by one clock.
      if (!m_busy) begin
        if (pri != 0) m_pc = tgt;
        m_busy = !stall;
      end else if (imem_ack) begin
        if (m_wrong) m_pc = accepted ? tgt : m_pend_tgt;
        else         m_pc = (pri != 0) ? tgt : m_pc + 32'd4;
        m_wrong = 1'b0; m_pend_pri = 0;
        m_busy  = !stall;
      end else if (accepted) begin
        m_wrong = 1'b1; m_pend_pri = pri; m_pend_tgt = tgt;
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    test_reset();
    test_seq_fetch();
    test_ack_wait();
    test_branch_ack();
    test_kill_priority();
    test_wrap();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
